// File: rtl/can_timing_pkg.sv
// rtl/can_timing_pkg.sv - shared types and defaults for the CAN time-quantum prescaler

package can_timing_pkg;

  localparam int DEF_REG_W = 16;
  localparam int DEF_DIV_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/prescale_ctrl_tq_counter.sv
// rtl/prescale_ctrl_tq_counter.sv - quantum counter, terminal compare and registered tq_tick

module tq_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             resync,
  input  logic [DIV_W-1:0] active,
  output logic             terminal,
  output logic             load,
  output logic             tq_tick
);

  logic [DIV_W-1:0] cnt;
  logic             at_end;

  assign at_end   = (cnt == active);
  // A resync on the terminal count still restarts the quantum but swallows its tick.
  assign terminal = count_en & at_end & ~resync;
  assign load     = count_en & (at_end | resync);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tq_tick <= 1'b0;
    end else if (!count_en) begin
      cnt     <= '0;
      tq_tick <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      tq_tick <= terminal;
    end else begin
      cnt     <= cnt + 1'b1;
      tq_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/prescale_ctrl.sv
// rtl/prescale_ctrl.sv - shadowed prescale register, enable FSM and time-quantum tick generation

module prescale_ctrl
  import can_timing_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu,
  input  logic [REG_W-1:0] reginp,
  input  logic             enable,
  input  logic             resync,
  output logic [REG_W-1:0] regout,
  output logic             tq_tick,
  output logic             upd_pending,
  output logic             running
);

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] active;
  logic             apply;
  logic             count_en;
  logic             cnt_terminal;
  logic             cnt_load;
  logic             unused_upper;

  assign unused_upper = ^reginp[REG_W-1:DIV_W];
  assign count_en     = (state_q == ST_RUN) & enable;

  tq_counter #(
    .DIV_W (DIV_W)
  ) u_tq_counter (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .resync   (resync),
    .active   (active),
    .terminal (cnt_terminal),
    .load     (cnt_load),
    .tq_tick  (tq_tick)
  );

  // apply marks the cycles where the shadow may move into the active divider:
  // any IDLE cycle, the LOAD cycle, and quantum boundaries in RUN.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        apply = upd_pending;
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        apply   = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = ST_IDLE;
        else         apply   = cnt_load & upd_pending;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow      <= '0;
      active      <= '0;
      upd_pending <= 1'b0;
    end else begin
      state_q <= state_d;
      if (apply) active <= shadow;
      // A write coinciding with an apply lands in the shadow and stays pending.
      if (cpu) begin
        shadow      <= reginp[DIV_W-1:0];
        upd_pending <= 1'b1;
      end else if (apply) begin
        upd_pending <= 1'b0;
      end
    end
  end

  assign regout  = {{(REG_W-DIV_W){1'b0}}, shadow};
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_prescale_ctrl.sv
// tb/tb_prescale_ctrl.sv - self-checking bench for prescale_ctrl

module tb_prescale_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu = 1'b0;
  logic [15:0] reginp = '0;
  logic        enable = 1'b0;
  logic        resync = 1'b0;
  logic [15:0] regout;
  logic        tq_tick;
  logic        upd_pending;
  logic        running;

  always #5 clk = ~clk;

  prescale_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu),
    .reginp      (reginp),
    .enable      (enable),
    .resync      (resync),
    .regout      (regout),
    .tq_tick     (tq_tick),
    .upd_pending (upd_pending),
    .running     (running)
  );

  int checks = 0;
  int errors = 0;

  // Reference: mode 0 idle, 1 load, 2 run; pos is the clock index inside the
  // current quantum and qlen the quantum length in clocks.
  int m_mode, m_pos, m_qlen, m_shadow;
  bit m_pending, m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input int d, input bit e, input bit rs);
    bit take;
    if (r) begin
      m_mode = 0; m_pos = 0; m_qlen = 1; m_shadow = 0; m_pending = 0; m_tick = 0;
      return;
    end
    take   = 0;
    m_tick = 0;
    if (m_mode == 0) begin
      m_pos = 0;
      take  = m_pending;
      if (e) m_mode = 1;
    end else if (m_mode == 1) begin
      m_pos  = 0;
      take   = 1;
      m_mode = 2;
    end else if (!e) begin
      m_mode = 0;
      m_pos  = 0;
    end else if (rs || m_pos == m_qlen - 1) begin
      m_tick = !rs;
      m_pos  = 0;
      take   = m_pending;
    end else begin
      m_pos++;
    end
    if (take) begin
      m_qlen    = m_shadow + 1;
      m_pending = 0;
    end
    if (c) begin
      m_shadow  = d % 256;
      m_pending = 1;
    end
  endtask

  task automatic cycle(input bit r, input bit c, input int d, input bit e, input bit rs);
    rst = r; cpu = c; reginp = 16'(d); enable = e; resync = rs;
    model_step(r, c, d, e, rs);
    @(posedge clk);
    #1;
    chk("m_regout", 32'(regout), 32'(m_shadow));
    chk("m_tick", 32'(tq_tick), 32'(m_tick));
    chk("m_pending", 32'(upd_pending), 32'(m_pending));
    chk("m_running", 32'(running), 32'(m_mode == 2));
  endtask

  task automatic run_until_tick(input int maxc, output int n);
    n = 0;
    do begin
      cycle(0, 0, 0, 1, 0);
      n++;
    end while (tq_tick !== 1'b1 && n < maxc);
    chk("tick_timeout", 32'(tq_tick), 32'd1);
  endtask

  initial begin
    int n;
    bit r, c, e, rs;
    int d;

    // Reset and idle write
    cycle(1, 0, 0, 0, 0);
    chk("rst_regout", 32'(regout), 32'h0);
    cycle(0, 1, 16'hAB05, 0, 0);
    chk("wr_regout", 32'(regout), 32'h0005);
    chk("wr_pending", 32'(upd_pending), 32'd1);
    cycle(0, 0, 0, 0, 0);
    chk("idle_apply", 32'(upd_pending), 32'd0);
    chk("idle_tick", 32'(tq_tick), 32'd0);

    // Enable, first tick and steady periods
    cycle(0, 0, 0, 1, 0);
    chk("load_running", 32'(running), 32'd0);
    cycle(0, 0, 0, 1, 0);
    chk("run_running", 32'(running), 32'd1);
    run_until_tick(50, n);
    chk("first_tick", 32'(n), 32'd6);
    for (int i = 0; i < 10; i++) begin
      run_until_tick(50, n);
      chk("period5", 32'(n), 32'd6);
    end

    // Mid-quantum write applies at the next boundary
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 3, 1, 0);
    run_until_tick(50, n);
    chk("midwr_len", 32'(n + 3), 32'd6);
    chk("midwr_pending", 32'(upd_pending), 32'd0);
    run_until_tick(50, n);
    chk("period3", 32'(n), 32'd4);

    // Write on the terminal cycle while another value is pending
    cycle(0, 1, 3, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 9, 1, 0);
    chk("termwr_tick", 32'(tq_tick), 32'd1);
    chk("termwr_pending", 32'(upd_pending), 32'd1);
    run_until_tick(50, n);
    chk("termwr_q1", 32'(n), 32'd4);
    chk("termwr_pending2", 32'(upd_pending), 32'd0);
    run_until_tick(50, n);
    chk("termwr_q2", 32'(n), 32'd10);

    // Resync mid-quantum and on the terminal count
    cycle(0, 1, 5, 1, 0);
    run_until_tick(50, n);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    chk("resync_mid_tick", 32'(tq_tick), 32'd0);
    run_until_tick(50, n);
    chk("resync_mid_len", 32'(n), 32'd6);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    chk("resync_term_tick", 32'(tq_tick), 32'd0);
    run_until_tick(50, n);
    chk("resync_term_len", 32'(n), 32'd6);

    // Divide by one holds the tick high
    cycle(0, 1, 0, 1, 0);
    run_until_tick(50, n);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("div1_tick", 32'(tq_tick), 32'd1);
    end

    // Enable drop mid-quantum
    cycle(0, 1, 5, 1, 0);
    run_until_tick(50, n);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("drop_running", 32'(running), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("drop_tick", 32'(tq_tick), 32'd0);
    end

    // Reset mid-run
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
    chk("prerst_running", 32'(running), 32'd1);
    cycle(1, 0, 0, 1, 0);
    chk("midrst_regout", 32'(regout), 32'h0);
    chk("midrst_tick", 32'(tq_tick), 32'd0);
    chk("midrst_pending", 32'(upd_pending), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);

    // Random traffic against the reference
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom % 150) == 0;
      c  = ($urandom % 8) == 0;
      d  = int'($urandom & 32'hFF00) | (($urandom % 10) == 0 ? int'($urandom % 256)
                                                                : int'($urandom_range(0, 7)));
      e  = ($urandom % 25) != 0;
      rs = ($urandom % 30) == 0;
      cycle(r, c, d, e, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescale_ctrl.md
Name: prescale_ctrl

Overview:
Time-quantum controller for the CAN bit-timing prescaler. Holds the CPU-written prescale value in a shadow register and applies it to the active divider only at a time-quantum boundary, so a divisor change never truncates a quantum. Generates the one-cycle tq_tick strobe that the bit-timing logic consumes. Supports enable/disable from the bus controller and hard-sync restart.

Parameters:
REG_W, 16, CPU-visible register width.
DIV_W, 8, effective divider width. Only reginp[DIV_W-1:0] is stored; upper bits read back as 0.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu  in  1  CPU write strobe, one cycle per write
reginp  in  REG_W  CPU write data
enable  in  1  bit timing enabled by the bus controller (level)
resync  in  1  hard-sync request, one-cycle pulse
regout  out  REG_W  shadow readback, {zeros, shadow[DIV_W-1:0]}
tq_tick  out  1  one-cycle pulse per time quantum, registered
upd_pending  out  1  shadow value not yet applied to the active divider
running  out  1  FSM is in RUN

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high.
  - Reset values: shadow=0, active=0, cnt=0, state=IDLE, regout=0, tq_tick=0, upd_pending=0, running=0.
  - Reset overrides every other input in the same cycle.
- CPU write (any state): when cpu=1, shadow <= reginp[DIV_W-1:0] and upd_pending <= 1. Back-to-back writes: the last write wins.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: cnt held at 0, tq_tick=0.
    - If enable=1, go to LOAD.
    - If upd_pending=1, active <= shadow and upd_pending <= 0 on the next cycle. This applies even while enable=0, so the divider is never stale.
  - LOAD (1 cycle): active <= shadow, upd_pending <= 0 unless cpu=1 in this cycle, cnt <= 0, then go to RUN.
  - RUN:
    - Terminal condition: cnt == active. Then cnt <= 0 and tq_tick <= 1 on the next cycle.
    - Otherwise cnt <= cnt+1 and tq_tick <= 0.
    - At terminal with upd_pending=1: active <= shadow and upd_pending <= 0.
    - enable=0 in RUN: go to IDLE on the next cycle, cnt <= 0, no tick issued for that cycle's compare.
- Tick period = active+1 clocks. active=0 gives a tick every clock (tq_tick held high). active=255 gives a period of 256.
- First tick after entering RUN comes active+1 cycles after the LOAD cycle.
- resync=1 in RUN: cnt <= 0 and tq_tick <= 0 for this compare, even if cnt==active. Any pending update is applied in the same cycle. resync is ignored in IDLE and LOAD.
- Simultaneous cpu write and RUN terminal: active <= the previous shadow if upd_pending was set. The newly written value goes to shadow and upd_pending stays 1, to be applied at the next boundary.
- cnt is DIV_W bits wide and can never exceed active. If active shrinks, the change is applied only at cnt=0, so wrap-around is impossible.
- running = (state==RUN), registered.

Decomposition:
- Package can_timing_pkg holds:
  - state enum/localparams ST_IDLE=2'd0, ST_LOAD=2'd1, ST_RUN=2'd2;
  - DIV_W and REG_W defaults.
- One natural sub-module, tq_counter: cnt, the terminal compare, resync clear and tq_tick register, with load/terminal outputs.
- The FSM, shadow register and pending flag stay in prescale_ctrl.

Test Plan:
1. Reset, then cpu write 16'hAB05 with enable=0 → regout=16'h0005; upd_pending=1 for one cycle, then 0; tq_tick stays 0.
2. active=5, enable=1 → running after LOAD; first tq_tick 6 cycles after LOAD; then ticks every 6 cycles for 10 periods.
3. Running with active=5, write 3 mid-quantum → current quantum still 6 cycles; the following quanta are 4 cycles; upd_pending clears at the boundary.
4. Write 9 in exactly the terminal cycle while 3 is pending → next quantum is 4 cycles, the one after is 10; upd_pending=1 until the second boundary.
5. resync pulse at cnt=4 with active=5 → no tick; the next tick comes 6 cycles after the resync cycle. Also resync at cnt==active → that tick is suppressed.
6. Corner cases:
   - active=0 → tq_tick high every cycle.
   - enable drop mid-quantum → IDLE next cycle, no further ticks.
   - rst=1 asserted mid-RUN → all outputs 0 on the next cycle.
